// File: rtl/rtc_pkg.sv
// Shared widths, BCD limits and the load-range check for the real-time-clock counter.
package rtc_pkg;

  localparam int DIGIT_W = 4;
  localparam int TIME_W  = 8;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;
  typedef logic [TIME_W-1:0]  bcd_time_t;

  localparam bcd_time_t SEC_MAX = 8'h59;
  localparam bcd_time_t MIN_MAX = 8'h59;
  localparam bcd_time_t H24_MAX = 8'h23;
  localparam bcd_time_t H12_MAX = 8'h12;
  localparam bcd_time_t H12_MIN = 8'h01;

  // Both nibbles must be decimal digits; packed BCD then compares correctly as binary.
  function automatic logic bcd_valid(input bcd_time_t value, input bcd_time_t max);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit: counts 0..MAX on en, parallel load on ld, carry when wrapping.
module bcd_digit_counter
  import rtc_pkg::*;
#(
  parameter bcd_digit_t MAX       = 4'd9,
  parameter bcd_digit_t RESET_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  output bcd_digit_t q,
  output logic       carry
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (ld) begin
      q <= ld_val;
    end else if (en) begin
      q <= (q == MAX) ? 4'd0 : q + 4'd1;
    end
  end

  assign carry = en & (q == MAX);

endmodule

// File: rtl/bcd_time_counter.sv
// hh:mm:ss packed-BCD clock advanced by rising edges of the 1 Hz divider output.
module bcd_time_counter
  import rtc_pkg::*;
#(
  parameter bit MODE_24H = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      sec_in,
  input  logic      run,
  input  logic      load,
  input  bcd_time_t load_hh,
  input  bcd_time_t load_mm,
  input  bcd_time_t load_ss,
  input  logic      load_pm,
  output bcd_time_t hh,
  output bcd_time_t mm,
  output bcd_time_t ss,
  output logic      pm,
  output logic      day_wrap,
  output logic      load_err
);

  localparam bcd_digit_t H1_MAX = MODE_24H ? 4'd2 : 4'd1;
  localparam bcd_digit_t H1_RST = MODE_24H ? 4'd0 : 4'd1;
  localparam bcd_digit_t H0_RST = MODE_24H ? 4'd0 : 4'd2;

  logic       sec_prev;
  logic       tick, adv;
  logic       hh_ok, load_ok;
  logic       hour_inc, hour_wrap, pm_toggle, wrap_day;
  logic       h_ld;
  bcd_time_t  h_ld_val, wrap_val;
  bcd_digit_t s0, s1, m0, m1, h0, h1;
  logic       s0_carry, s1_carry, m0_carry, m1_carry, h0_carry;
  logic       unused_h1_carry;
  logic       pm_q;

  assign tick = sec_in & ~sec_prev & run;
  // A load owns the edge: any coincident tick is dropped, valid or not.
  assign adv  = tick & ~load;

  assign hh_ok   = MODE_24H ? bcd_valid(load_hh, H24_MAX)
                            : (bcd_valid(load_hh, H12_MAX) && (load_hh >= H12_MIN));
  assign load_ok = load & hh_ok & bcd_valid(load_mm, MIN_MAX) & bcd_valid(load_ss, SEC_MAX);

  assign hh       = {h1, h0};
  assign mm       = {m1, m0};
  assign ss       = {s1, s0};
  assign pm       = pm_q;

  assign hour_inc  = m1_carry;
  assign hour_wrap = hour_inc & (hh == (MODE_24H ? H24_MAX : H12_MAX));
  assign wrap_val  = MODE_24H ? 8'h00 : H12_MIN;
  assign pm_toggle = ~MODE_24H & hour_inc & (hh == 8'h11);
  // 12 h mode starts a new day on 11 PM -> 12 AM, not on the 12 -> 01 wrap.
  assign wrap_day  = MODE_24H ? hour_wrap : (pm_toggle & pm_q);

  assign h_ld     = load_ok | hour_wrap;
  assign h_ld_val = load_ok ? load_hh : wrap_val;

  bcd_digit_counter #(.MAX(4'd9), .RESET_VAL(4'd0)) u_s0 (
    .clk(clk), .reset(reset), .en(adv), .ld(load_ok), .ld_val(load_ss[3:0]),
    .q(s0), .carry(s0_carry)
  );

  bcd_digit_counter #(.MAX(4'd5), .RESET_VAL(4'd0)) u_s1 (
    .clk(clk), .reset(reset), .en(s0_carry), .ld(load_ok), .ld_val(load_ss[7:4]),
    .q(s1), .carry(s1_carry)
  );

  bcd_digit_counter #(.MAX(4'd9), .RESET_VAL(4'd0)) u_m0 (
    .clk(clk), .reset(reset), .en(s1_carry), .ld(load_ok), .ld_val(load_mm[3:0]),
    .q(m0), .carry(m0_carry)
  );

  bcd_digit_counter #(.MAX(4'd5), .RESET_VAL(4'd0)) u_m1 (
    .clk(clk), .reset(reset), .en(m0_carry), .ld(load_ok), .ld_val(load_mm[7:4]),
    .q(m1), .carry(m1_carry)
  );

  // Hours count freely as decimal; the 23->00 / 12->01 wrap is forced through ld.
  bcd_digit_counter #(.MAX(4'd9), .RESET_VAL(H0_RST)) u_h0 (
    .clk(clk), .reset(reset), .en(hour_inc), .ld(h_ld), .ld_val(h_ld_val[3:0]),
    .q(h0), .carry(h0_carry)
  );

  bcd_digit_counter #(.MAX(H1_MAX), .RESET_VAL(H1_RST)) u_h1 (
    .clk(clk), .reset(reset), .en(h0_carry), .ld(h_ld), .ld_val(h_ld_val[7:4]),
    .q(h1), .carry(unused_h1_carry)
  );

  always_ff @(posedge clk) begin
    sec_prev <= sec_in;
    if (reset) begin
      pm_q     <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      day_wrap <= wrap_day;
      load_err <= load & ~load_ok;
      if (load_ok) begin
        pm_q <= MODE_24H ? 1'b0 : load_pm;
      end else if (pm_toggle) begin
        pm_q <= ~pm_q;
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench: a 24 h and a 12 h instance share stimulus; each scenario checks the relevant one.
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       reset, sec_in, run, load, load_pm;
  logic [7:0] load_hh, load_mm, load_ss;
  logic [7:0] hh24, mm24, ss24, hh12, mm12, ss12;
  logic       pm24, pm12, dw24, dw12, le24, le12;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  bcd_time_counter #(.MODE_24H(1'b1)) dut24 (
    .clk(clk), .reset(reset), .sec_in(sec_in), .run(run), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
    .hh(hh24), .mm(mm24), .ss(ss24), .pm(pm24), .day_wrap(dw24), .load_err(le24)
  );

  bcd_time_counter #(.MODE_24H(1'b0)) dut12 (
    .clk(clk), .reset(reset), .sec_in(sec_in), .run(run), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
    .hh(hh12), .mm(mm12), .ss(ss12), .pm(pm12), .day_wrap(dw12), .load_err(le12)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    sec_in = 1'b1;
    step();
    sec_in = 1'b0;
    step();
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input logic p);
    load_hh = h; load_mm = m; load_ss = s; load_pm = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; sec_in = 1'b1;
    step(); step();
    checks++;
    if ({hh24, mm24, ss24, dw24, le24} !== {24'h000000, 2'b00}) begin
      failures++;
      $display("FAIL reset24 got %h:%h:%h dw=%b le=%b want 00:00:00 0 0", hh24, mm24, ss24, dw24, le24);
    end
    checks++;
    if ({hh12, mm12, ss12, pm12} !== {24'h120000, 1'b0}) begin
      failures++;
      $display("FAIL reset12 got %h:%h:%h pm=%b want 12:00:00 pm=0", hh12, mm12, ss12, pm12);
    end
    reset = 1'b0;
    step();
    checks++;
    if (ss24 !== 8'h00) begin
      failures++;
      $display("FAIL no_tick_at_release got ss=%h want 00", ss24);
    end
    sec_in = 1'b0;
    step();
    do_tick(); do_tick(); do_tick();
    checks++;
    if ({hh24, mm24, ss24} !== 24'h000003) begin
      failures++;
      $display("FAIL three_ticks24 got %h:%h:%h want 00:00:03", hh24, mm24, ss24);
    end
    checks++;
    if ({hh12, mm12, ss12} !== 24'h120003) begin
      failures++;
      $display("FAIL three_ticks12 got %h:%h:%h want 12:00:03", hh12, mm12, ss12);
    end
  endtask

  task automatic test_carry();
    do_load(8'h00, 8'h00, 8'h59, 1'b0);
    do_tick();
    checks++;
    if ({hh24, mm24, ss24} !== 24'h000100) begin
      failures++;
      $display("FAIL sec_carry got %h:%h:%h want 00:01:00", hh24, mm24, ss24);
    end
    do_load(8'h00, 8'h59, 8'h59, 1'b0);
    do_tick();
    checks++;
    if ({hh24, mm24, ss24} !== 24'h010000) begin
      failures++;
      $display("FAIL min_carry got %h:%h:%h want 01:00:00", hh24, mm24, ss24);
    end
    do_load(8'h09, 8'h59, 8'h59, 1'b0);
    do_tick();
    checks++;
    if ({hh24, mm24, ss24} !== 24'h100000) begin
      failures++;
      $display("FAIL hour_digit_carry got %h:%h:%h want 10:00:00", hh24, mm24, ss24);
    end
  endtask

  task automatic test_wrap24();
    do_load(8'h23, 8'h59, 8'h59, 1'b0);
    checks++;
    if (dw24 !== 1'b0) begin
      failures++;
      $display("FAIL load_no_wrap got dw=%b want 0", dw24);
    end
    sec_in = 1'b1;
    step();
    checks++;
    if ({hh24, mm24, ss24, dw24} !== {24'h000000, 1'b1}) begin
      failures++;
      $display("FAIL wrap24 got %h:%h:%h dw=%b want 00:00:00 dw=1", hh24, mm24, ss24, dw24);
    end
    sec_in = 1'b0;
    step();
    checks++;
    if (dw24 !== 1'b0) begin
      failures++;
      $display("FAIL wrap24_pulse got dw=%b want 0", dw24);
    end
  endtask

  task automatic test_12h();
    do_load(8'h11, 8'h59, 8'h59, 1'b0);
    do_tick();
    checks++;
    if ({hh12, mm12, ss12, pm12, dw12} !== {24'h120000, 2'b10}) begin
      failures++;
      $display("FAIL noon got %h:%h:%h pm=%b dw=%b want 12:00:00 pm=1 dw=0", hh12, mm12, ss12, pm12, dw12);
    end
    do_load(8'h12, 8'h59, 8'h59, 1'b1);
    do_tick();
    checks++;
    if ({hh12, mm12, ss12, pm12} !== {24'h010000, 1'b1}) begin
      failures++;
      $display("FAIL wrap12_01 got %h:%h:%h pm=%b want 01:00:00 pm=1", hh12, mm12, ss12, pm12);
    end
    do_load(8'h11, 8'h59, 8'h59, 1'b1);
    sec_in = 1'b1;
    step();
    checks++;
    if ({hh12, mm12, ss12, pm12, dw12} !== {24'h120000, 2'b01}) begin
      failures++;
      $display("FAIL midnight got %h:%h:%h pm=%b dw=%b want 12:00:00 pm=0 dw=1", hh12, mm12, ss12, pm12, dw12);
    end
    sec_in = 1'b0;
    step();
    checks++;
    if (dw12 !== 1'b0) begin
      failures++;
      $display("FAIL midnight_pulse got dw=%b want 0", dw12);
    end
  endtask

  task automatic test_invalid_load();
    do_load(8'h10, 8'h20, 8'h30, 1'b0);
    do_load(8'h10, 8'h20, 8'h60, 1'b0);
    checks++;
    if ({hh24, mm24, ss24, le24, le12} !== {24'h102030, 2'b11}) begin
      failures++;
      $display("FAIL bad_ss got %h:%h:%h le24=%b le12=%b want 10:20:30 1 1", hh24, mm24, ss24, le24, le12);
    end
    step();
    checks++;
    if (le24 !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse got le=%b want 0", le24);
    end
    do_load(8'h10, 8'h5A, 8'h30, 1'b0);
    checks++;
    if ({hh24, mm24, ss24, le24} !== {24'h102030, 1'b1}) begin
      failures++;
      $display("FAIL bad_mm got %h:%h:%h le=%b want 10:20:30 1", hh24, mm24, ss24, le24);
    end
    do_load(8'h24, 8'h20, 8'h30, 1'b0);
    checks++;
    if ({hh24, mm24, ss24, le24} !== {24'h102030, 1'b1}) begin
      failures++;
      $display("FAIL bad_hh24 got %h:%h:%h le=%b want 10:20:30 1", hh24, mm24, ss24, le24);
    end
    do_load(8'h00, 8'h20, 8'h30, 1'b0);
    checks++;
    if ({hh12, mm12, ss12, pm12, le12} !== {24'h102030, 2'b01}) begin
      failures++;
      $display("FAIL bad_hh12 got %h:%h:%h pm=%b le=%b want 10:20:30 pm=0 1", hh12, mm12, ss12, pm12, le12);
    end
    checks++;
    if ({hh24, mm24, ss24, le24} !== {24'h002030, 1'b0}) begin
      failures++;
      $display("FAIL hh00_24 got %h:%h:%h le=%b want 00:20:30 0", hh24, mm24, ss24, le24);
    end
  endtask

  task automatic test_run_and_load_tick();
    do_load(8'h10, 8'h20, 8'h30, 1'b0);
    run = 1'b0;
    do_tick(); do_tick();
    run = 1'b1;
    step();
    checks++;
    if ({hh24, mm24, ss24} !== 24'h102030) begin
      failures++;
      $display("FAIL paused got %h:%h:%h want 10:20:30", hh24, mm24, ss24);
    end
    sec_in = 1'b1;
    do_load(8'h05, 8'h06, 8'h07, 1'b0);
    sec_in = 1'b0;
    step();
    checks++;
    if ({hh24, mm24, ss24, hh12, mm12, ss12} !== 48'h050607_050607) begin
      failures++;
      $display("FAIL load_with_tick got %h:%h:%h / %h:%h:%h want 05:06:07", hh24, mm24, ss24, hh12, mm12, ss12);
    end
  endtask

  task automatic test_reset_mid();
    do_tick(); do_tick();
    checks++;
    if ({hh24, mm24, ss24} !== 24'h050609) begin
      failures++;
      $display("FAIL resume got %h:%h:%h want 05:06:09", hh24, mm24, ss24);
    end
    sec_in = 1'b1; load = 1'b1; load_hh = 8'h07; load_mm = 8'h07; load_ss = 8'h07;
    reset = 1'b1;
    step();
    load = 1'b0; reset = 1'b0; sec_in = 1'b0;
    checks++;
    if ({hh24, mm24, ss24, hh12, mm12, ss12, pm12} !== {48'h000000_120000, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid got %h:%h:%h / %h:%h:%h pm=%b want 00:00:00 / 12:00:00 pm=0",
               hh24, mm24, ss24, hh12, mm12, ss12, pm12);
    end
    step();
  endtask

  initial begin
    reset = 1'b1; sec_in = 1'b0; run = 1'b1; load = 1'b0; load_pm = 1'b0;
    load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
    test_reset();
    test_carry();
    test_wrap24();
    test_12h();
    test_invalid_load();
    test_run_and_load_tick();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
